// File: rtl/fg_pkg.sv
// Shared constants and types for the function-generator DAC write path.
package fg_pkg;

  localparam int         FRAME_W    = 16;
  localparam logic [3:0] DAC_CMD_WU = 4'b0011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } seq_state_t;

endpackage

// File: rtl/fg_spi_shifter.sv
// MSB-first SPI frame serialiser: CS frames the transfer, SCLK idles low and is
// divided from the system clock, MOSI moves on the SCLK falling edge.
module fg_spi_shifter #(
  parameter int FRAME_W = 16,
  parameter int CLK_DIV = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic [FRAME_W-1:0] frame_i,
  output logic               done_o,
  output logic               cs_n_o,
  output logic               sclk_o,
  output logic               mosi_o
);

  localparam int BIT_W = $clog2(FRAME_W) + 1;
  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic               active_q;
  logic [FRAME_W-1:0] sreg_q;
  logic [BIT_W-1:0]   bit_q;
  logic [DIV_W-1:0]   div_q;
  logic               sclk_q;
  logic               cs_n_q;
  logic               mosi_q;
  logic               div_end_s;

  assign div_end_s = active_q & (div_q == DIV_LAST);
  // High in the final SCLK-high half period: the edge that releases CS.
  assign done_o    = div_end_s & sclk_q & (bit_q == BIT_LAST);
  assign cs_n_o    = cs_n_q;
  assign sclk_o    = sclk_q;
  assign mosi_o    = mosi_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      active_q <= 1'b0;
      sreg_q   <= '0;
      bit_q    <= '0;
      div_q    <= '0;
      sclk_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      mosi_q   <= 1'b0;
    end else if (load_i) begin
      active_q <= 1'b1;
      sreg_q   <= frame_i;
      bit_q    <= '0;
      div_q    <= '0;
      sclk_q   <= 1'b0;
      cs_n_q   <= 1'b0;
      mosi_q   <= frame_i[FRAME_W-1];
    end else if (div_end_s) begin
      div_q <= '0;
      if (!sclk_q) begin
        sclk_q <= 1'b1;
      end else begin
        sclk_q <= 1'b0;
        if (bit_q == BIT_LAST) begin
          active_q <= 1'b0;
          cs_n_q   <= 1'b1;
          mosi_q   <= 1'b0;
        end else begin
          bit_q  <= bit_q + BIT_W'(1);
          sreg_q <= {sreg_q[FRAME_W-2:0], 1'b0};
          mosi_q <= sreg_q[FRAME_W-2];
        end
      end
    end else if (active_q) begin
      div_q <= div_q + DIV_W'(1);
    end else begin
      div_q <= '0;
    end
  end

endmodule

// File: rtl/fg_dac_sequencer.sv
// Arbitrates sample ticks and config writes onto the shared SPI DAC and
// sequences each frame through LOAD, SHIFT and an inter-frame GAP.
module fg_dac_sequencer
  import fg_pkg::*;
#(
  parameter int DATA_W     = FRAME_W - 4,
  parameter int CLK_DIV    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic               fg_clk_i,
  input  logic               reset_i,
  input  logic               ready_i,
  input  logic               enable_i,
  input  logic [DATA_W-1:0]  sample_i,
  input  logic               cfg_req_i,
  input  logic [FRAME_W-1:0] cfg_word_i,
  output logic               cfg_gnt_o,
  output logic               cfg_done_o,
  output logic               dac_cs_n_o,
  output logic               dac_sclk_o,
  output logic               dac_mosi_o,
  output logic               busy_o,
  output logic               overrun_o
);

  localparam int DIV_W    = $clog2(CLK_DIV) + 1;
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  localparam logic [DIV_W-1:0]    GAP_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [STARVE_W-1:0] STARVE_TOP = STARVE_W'(STARVE_MAX);

  seq_state_t          state_q, state_d;
  logic                armed_q;
  logic                pending_q;
  logic [DATA_W-1:0]   pend_buf_q;
  logic                src_cfg_q;
  logic [STARVE_W-1:0] starve_q;
  logic [DIV_W-1:0]    gap_q, gap_d;
  logic                cfg_gnt_q, cfg_done_q, busy_q, overrun_q;

  logic               start_s, pick_sample_s, consume_s, shift_done_s;
  logic [FRAME_W-1:0] frame_s;

  assign start_s       = armed_q & (pending_q | cfg_req_i);
  // A held config request wins once STARVE_MAX samples have gone ahead of it.
  assign pick_sample_s = pending_q & ~(cfg_req_i & (starve_q == STARVE_TOP));
  assign consume_s     = (state_q == LOAD) & ~src_cfg_q;
  assign frame_s       = src_cfg_q ? cfg_word_i : {DAC_CMD_WU, pend_buf_q};
  assign gap_d         = (state_q == GAP) ? gap_q + DIV_W'(1) : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start_s ? LOAD : IDLE;
      LOAD:    state_d = SHIFT;
      SHIFT:   state_d = shift_done_s ? GAP : SHIFT;
      GAP:     state_d = (gap_q == GAP_LAST) ? IDLE : GAP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge fg_clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      armed_q    <= 1'b0;
      pending_q  <= 1'b0;
      pend_buf_q <= '0;
      src_cfg_q  <= 1'b0;
      starve_q   <= '0;
      gap_q      <= '0;
      cfg_gnt_q  <= 1'b0;
      cfg_done_q <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      busy_q     <= (state_d != IDLE);
      armed_q    <= armed_q | ready_i;
      cfg_gnt_q  <= (state_q == IDLE) & start_s & ~pick_sample_s;
      cfg_done_q <= src_cfg_q & (state_d == GAP) & (gap_d == GAP_LAST);

      if ((state_q == IDLE) && start_s) begin
        src_cfg_q <= ~pick_sample_s;
      end

      if ((state_q == IDLE) && !cfg_req_i) begin
        starve_q <= '0;
      end else if ((state_q == LOAD) && src_cfg_q) begin
        starve_q <= '0;
      end else if (consume_s && cfg_req_i && (starve_q != STARVE_TOP)) begin
        starve_q <= starve_q + STARVE_W'(1);
      end

      // A new tick in the LOAD cycle refills the slot being emptied: no overrun.
      if (armed_q && enable_i) begin
        pend_buf_q <= sample_i;
        pending_q  <= 1'b1;
        overrun_q  <= pending_q & ~consume_s;
      end else begin
        overrun_q  <= 1'b0;
        if (consume_s) begin
          pending_q <= 1'b0;
        end
      end
    end
  end

  fg_spi_shifter #(
    .FRAME_W (FRAME_W),
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk_i   (fg_clk_i),
    .reset_i (reset_i),
    .load_i  (state_q == LOAD),
    .frame_i (frame_s),
    .done_o  (shift_done_s),
    .cs_n_o  (dac_cs_n_o),
    .sclk_o  (dac_sclk_o),
    .mosi_o  (dac_mosi_o)
  );

  assign cfg_gnt_o  = cfg_gnt_q;
  assign cfg_done_o = cfg_done_q;
  assign busy_o     = busy_q;
  assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_fg_dac_sequencer.sv
// Directed bench: expected SPI frames are queued as stimulus is applied and
// compared when each frame completes on the DAC pins.
module tb_fg_dac_sequencer;

  logic        clk = 1'b0;
  logic        reset, ready, cfg_req, cfg_req1;
  logic        en0, en1;
  logic [11:0] samp0, samp1;
  logic [15:0] cfg_word;
  logic [1:0]  gnt, done, cs_n, sclk, mosi, busy, ovr;

  int checks = 0;
  int errors = 0;
  int gnt_cnt = 0;
  int ovr_cnt [2] = '{0, 0};
  int frames_seen [2] = '{0, 0};
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  fg_dac_sequencer #(.DATA_W(12), .CLK_DIV(2), .STARVE_MAX(4)) u_dut0 (
    .fg_clk_i(clk), .reset_i(reset), .ready_i(ready), .enable_i(en0), .sample_i(samp0),
    .cfg_req_i(cfg_req), .cfg_word_i(cfg_word), .cfg_gnt_o(gnt[0]), .cfg_done_o(done[0]),
    .dac_cs_n_o(cs_n[0]), .dac_sclk_o(sclk[0]), .dac_mosi_o(mosi[0]), .busy_o(busy[0]),
    .overrun_o(ovr[0]));

  fg_dac_sequencer #(.DATA_W(12), .CLK_DIV(1), .STARVE_MAX(4)) u_dut1 (
    .fg_clk_i(clk), .reset_i(reset), .ready_i(ready), .enable_i(en1), .sample_i(samp1),
    .cfg_req_i(cfg_req1), .cfg_word_i(cfg_word), .cfg_gnt_o(gnt[1]), .cfg_done_o(done[1]),
    .dac_cs_n_o(cs_n[1]), .dac_sclk_o(sclk[1]), .dac_mosi_o(mosi[1]), .busy_o(busy[1]),
    .overrun_o(ovr[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (gnt[0]) gnt_cnt++;
    if (ovr[0]) ovr_cnt[0]++;
    if (ovr[1]) ovr_cnt[1]++;
  end

  // Per-instance SPI receiver: rebuilds each frame and checks it against the queue.
  for (genvar g = 0; g < 2; g++) begin : g_mon
    localparam int LOWC = 16 * 2 * ((g == 0) ? 2 : 1);
    logic [15:0] rx = '0;
    logic [15:0] e;
    int   nbits = 0;
    int   lowc = 0;
    logic prev_cs = 1'b1;
    logic prev_sclk = 1'b0;
    logic in_frame = 1'b0;

    always @(negedge clk) begin
      if (reset) begin
        in_frame  = 1'b0;
        prev_cs   = 1'b1;
        prev_sclk = 1'b0;
      end else begin
        if (prev_cs && !cs_n[g]) begin
          in_frame = 1'b1;
          rx = '0;
          nbits = 0;
          lowc = 0;
        end
        if (in_frame && !cs_n[g]) lowc++;
        if (in_frame && !prev_sclk && sclk[g]) begin
          rx = {rx[14:0], mosi[g]};
          nbits++;
        end
        if (in_frame && !prev_cs && cs_n[g]) begin
          in_frame = 1'b0;
          frames_seen[g]++;
          chk("frame_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("frame_data", 32'(rx), 32'(e));
          end
          chk("frame_bits", 32'(nbits), 32'd16);
          chk("cs_low_cycles", 32'(lowc), 32'(LOWC));
        end
        prev_cs   = cs_n[g];
        prev_sclk = sclk[g];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    int base;
    int gnt_k;
    logic got;
    reset = 1'b1; ready = 1'b0; cfg_req = 1'b0; cfg_req1 = 1'b0;
    en0 = 1'b0; en1 = 1'b0; samp0 = '0; samp1 = '0; cfg_word = '0;
    cyc(3);
    chk("reset_outputs", 32'({cs_n[0], sclk[0], mosi[0], busy[0], gnt[0], done[0], ovr[0]}),
        32'b1000000);
    reset = 1'b0;
    cyc(2);

    // Unarmed: ticks and config requests are ignored.
    samp0 = 12'h123; en0 = 1'b1; cyc(1); en0 = 1'b0;
    cfg_word = 16'h1111; cfg_req = 1'b1; cyc(6); cfg_req = 1'b0;
    chk("unarmed_idle", 32'({cs_n[0], busy[0]}), 32'b10);
    chk("unarmed_no_gnt", 32'(gnt_cnt), 32'd0);
    ready = 1'b1; cyc(1); ready = 1'b0; cyc(2);

    // First sample frame and its latency.
    exp_q.push_back(16'h3ABC);
    samp0 = 12'hABC; en0 = 1'b1; cyc(1); en0 = 1'b0;
    cyc(1); chk("latency_cs_t1", 32'(cs_n[0]), 32'd1);
    cyc(1); chk("latency_cs_t2", 32'({cs_n[0], busy[0]}), 32'b01);
    cyc(1); chk("latency_sclk_pre", 32'(sclk[0]), 32'd0);
    cyc(1); chk("latency_sclk_rise", 32'(sclk[0]), 32'd1);
    cyc(70);
    chk("frame1_idle", 32'({busy[0], cs_n[0], sclk[0]}), 32'b010);

    // Two ticks during SHIFT: the older one is overwritten.
    base = ovr_cnt[0];
    exp_q.push_back(16'h3111);
    samp0 = 12'h111; en0 = 1'b1; cyc(1); en0 = 1'b0;
    cyc(5); samp0 = 12'h005; en0 = 1'b1; cyc(1); en0 = 1'b0;
    cyc(9); samp0 = 12'h006; en0 = 1'b1; cyc(1); en0 = 1'b0;
    exp_q.push_back(16'h3006);
    cyc(160);
    chk("overrun_once", 32'(ovr_cnt[0] - base), 32'd1);

    // Config write from idle.
    base = gnt_cnt;
    exp_q.push_back(16'hF00D);
    cfg_word = 16'hF00D; cfg_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      cyc(1);
      if (gnt[0]) got = 1'b1;
    end
    cfg_req = 1'b0;
    chk("cfg_gnt_seen", 32'(got), 32'd1);
    cyc(1); chk("cfg_gnt_pulse", 32'(gnt[0]), 32'd0);
    cyc(64); chk("cfg_done_early", 32'({done[0], cs_n[0]}), 32'b01);
    cyc(1);  chk("cfg_done_pulse", 32'({done[0], busy[0]}), 32'b11);
    cyc(1);  chk("cfg_done_end", 32'({done[0], busy[0]}), 32'b00);
    chk("cfg_gnt_count", 32'(gnt_cnt - base), 32'd1);
    cyc(5);

    // Held config request yields to four sample frames, then wins once.
    base = gnt_cnt;
    gnt_k = -1;
    cfg_word = 16'hC0DE;
    exp_q.push_back(16'h3401); exp_q.push_back(16'h3402);
    exp_q.push_back(16'h3403); exp_q.push_back(16'h3404);
    exp_q.push_back(16'hC0DE); exp_q.push_back(16'h3405);
    for (int k = 0; k < 5; k++) begin
      samp0 = 12'h401 + 12'(k); en0 = 1'b1; cyc(1); en0 = 1'b0;
      if (k == 0) cfg_req = 1'b1;
      for (int i = 0; i < 67; i++) begin
        cyc(1);
        if (gnt[0]) begin
          cfg_req = 1'b0;
          gnt_k = k;
        end
      end
    end
    cfg_req = 1'b0;
    cyc(80);
    chk("starve_gnt_slot", 32'(gnt_k), 32'd4);
    chk("starve_gnt_count", 32'(gnt_cnt - base), 32'd1);
    chk("starve_no_overrun", 32'(ovr_cnt[0]), 32'd1);

    // Reset in the middle of a frame aborts it and disarms.
    samp0 = 12'h777; en0 = 1'b1; cyc(1); en0 = 1'b0;
    cyc(20);
    chk("pre_reset_shifting", 32'({cs_n[0], busy[0]}), 32'b01);
    reset = 1'b1; cyc(1);
    chk("reset_abort", 32'({cs_n[0], sclk[0], busy[0]}), 32'b100);
    reset = 1'b0; cyc(1);
    samp0 = 12'h888; en0 = 1'b1; cyc(1); en0 = 1'b0;
    cyc(10);
    chk("post_reset_unarmed", 32'({cs_n[0], busy[0]}), 32'b10);
    ready = 1'b1; cyc(1); ready = 1'b0; cyc(2);

    // CLK_DIV=1 build: ticks at the 35-cycle frame period, no overrun.
    base = frames_seen[1];
    exp_q.push_back(16'h3601);
    samp1 = 12'h601; en1 = 1'b1; cyc(1); en1 = 1'b0;
    cyc(2); chk("div1_cs_low", 32'({cs_n[1], sclk[1]}), 32'b00);
    cyc(1); chk("div1_sclk_rise", 32'(sclk[1]), 32'd1);
    cyc(31);
    for (int k = 1; k < 4; k++) begin
      exp_q.push_back(16'h3601 + 16'(k));
      samp1 = 12'h601 + 12'(k); en1 = 1'b1; cyc(1); en1 = 1'b0;
      cyc(34);
    end
    cyc(40);
    chk("div1_no_overrun", 32'(ovr_cnt[1]), 32'd0);
    chk("div1_frames", 32'(frames_seen[1] - base), 32'd4);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
